// File: rtl/fpu_pkg.sv
// Shared types and helpers for the iterative FP divider.
package fpu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StDivide,
        StNorm,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } cls_e;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    // Quiet NaN: sign 0, exponent all ones, fraction MSB set.
    function automatic logic [127:0] canon_nan(input int unsigned exp_w,
                                               input int unsigned man_w);
        logic [127:0] v;
        v = ((128'd1 << exp_w) - 128'd1) << man_w;
        v = v | (128'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fpu_unpack.sv
// Splits one FP word into sign/exponent/mantissa and classifies it.
// Subnormals are flushed to zero.
module fpu_unpack
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op,
    output logic                 sign,
    output logic [EXP_W-1:0]     exp,
    output logic [MAN_W:0]       mant,
    output cls_e                 cls
);

    logic [MAN_W-1:0] frac;

    always_comb begin
        sign = op[EXP_W+MAN_W];
        exp  = op[EXP_W+MAN_W-1:MAN_W];
        frac = op[MAN_W-1:0];
        mant = {1'b1, frac};
        if (exp == '0) begin
            cls  = CLS_ZERO;
            mant = '0;
        end else if (exp == '1) begin
            cls = (frac != '0) ? CLS_NAN : CLS_INF;
        end else begin
            cls = CLS_NORM;
        end
    end

endmodule

// File: rtl/fpu_div_iter.sv
// Multi-cycle FP divider: restoring mantissa divide, valid/ready on both sides.
// Define FPU_DIV_RNE_EN for round-to-nearest-even; default truncates toward zero.
module fpu_div_iter
    import fpu_pkg::*;
#(
    parameter  int unsigned EXP_W         = 8,
    parameter  int unsigned MAN_W         = 23,
    localparam int unsigned FORMAT_LENGTH = 1 + EXP_W + MAN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FORMAT_LENGTH-1:0] op_a,
    input  logic [FORMAT_LENGTH-1:0] op_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FORMAT_LENGTH-1:0] result,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     invalid,
    output logic                     div_by_zero
);

    localparam int unsigned FL    = FORMAT_LENGTH;
    localparam int unsigned QW    = MAN_W + 3;
    localparam int unsigned RW    = MAN_W + 2;
    localparam int unsigned EW    = EXP_W + 2;
    localparam int unsigned CNT_W = $clog2(QW);

    localparam logic [CNT_W-1:0]     LAST_STEP = CNT_W'(QW - 1);
    localparam logic signed [EW-1:0] BIAS_E    = EW'(bias(EXP_W));
    localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_E     = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E    = EW'(0);
    localparam logic [FL-1:0]        QNAN      = FL'(canon_nan(EXP_W, MAN_W));

    state_e state_q, state_d;

    logic [FL-1:0]        a_q, b_q;
    logic                 sign_q, special_q;
    logic signed [EW-1:0] exp_q;
    logic [MAN_W:0]       div_q;
    logic [RW-1:0]        rem_q;
    logic [QW-1:0]        quo_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [FL-1:0]        res_q;
    logic                 of_q, uf_q, inv_q, dbz_q;

    logic           sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W:0] ma, mb;
    cls_e           ca, cb;

    fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .op  (a_q),
        .sign(sa),
        .exp (ea),
        .mant(ma),
        .cls (ca)
    );

    fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .op  (b_q),
        .sign(sb),
        .exp (eb),
        .mant(mb),
        .cls (cb)
    );

    logic          sign_ab, is_special, sp_inv, sp_dbz;
    logic [FL-1:0] sp_res;

    always_comb begin
        sign_ab    = sa ^ sb;
        is_special = 1'b1;
        sp_inv     = 1'b0;
        sp_dbz     = 1'b0;
        sp_res     = '0;
        if (ca == CLS_NAN || cb == CLS_NAN || (ca == CLS_ZERO && cb == CLS_ZERO) ||
            (ca == CLS_INF && cb == CLS_INF)) begin
            sp_res = QNAN;
            sp_inv = 1'b1;
        end else if (cb == CLS_ZERO) begin
            sp_res = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            sp_dbz = 1'b1;
        end else if (ca == CLS_INF) begin
            sp_res = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (ca == CLS_ZERO || cb == CLS_INF) begin
            sp_res = {sign_ab, {(FL-1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

    // Restoring step; after a subtract the remainder is below the divisor, so the shift is safe.
    logic          rem_ge;
    logic [RW-1:0] rem_sub, rem_next;

    always_comb begin
        rem_ge   = rem_q >= {1'b0, div_q};
        rem_sub  = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
        rem_next = {rem_sub[RW-2:0], 1'b0};
    end

    logic [MAN_W-1:0]     frac, frac_r;
    logic signed [EW-1:0] e_n, e_r;
    logic [FL-1:0]        norm_res;
    logic                 norm_of, norm_uf;
`ifdef FPU_DIV_RNE_EN
    logic           guard, sticky, inc;
    logic [MAN_W:0] frac_sum;
`endif

    always_comb begin
        frac = quo_q[QW-1] ? quo_q[QW-2:2] : quo_q[QW-3:1];
        e_n  = quo_q[QW-1] ? exp_q : (exp_q - ONE_E);
`ifdef FPU_DIV_RNE_EN
        guard    = quo_q[QW-1] ? quo_q[1] : quo_q[0];
        sticky   = (quo_q[QW-1] & quo_q[0]) | (|rem_q);
        inc      = guard & (sticky | frac[0]);
        frac_sum = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
        // Carry out means the mantissa hit 2.0: fraction wraps to zero, exponent bumps.
        frac_r   = frac_sum[MAN_W-1:0];
        e_r      = frac_sum[MAN_W] ? (e_n + ONE_E) : e_n;
`else
        frac_r = frac;
        e_r    = e_n;
`endif
        norm_of  = 1'b0;
        norm_uf  = 1'b0;
        norm_res = {sign_q, e_r[EXP_W-1:0], frac_r};
        if (e_r >= EXP_MAX) begin
            norm_of  = 1'b1;
            norm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (e_r <= ZERO_E) begin
            norm_uf  = 1'b1;
            norm_res = {sign_q, {(FL-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Specials also pass through NORM (unchanged) so every result leaves from one stage.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (in_valid) state_d = StUnpack;
            StUnpack: state_d = is_special ? StNorm : StDivide;
            StDivide: if (cnt_q == LAST_STEP) state_d = StNorm;
            StNorm:   state_d = StDone;
            StDone:   if (out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == StIdle);
        out_valid   = (state_q == StDone);
        result      = res_q;
        overflow    = of_q;
        underflow   = uf_q;
        invalid     = inv_q;
        div_by_zero = dbz_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            special_q <= 1'b0;
            exp_q     <= '0;
            div_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            of_q      <= 1'b0;
            uf_q      <= 1'b0;
            inv_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        res_q <= '0;
                        of_q  <= 1'b0;
                        uf_q  <= 1'b0;
                        inv_q <= 1'b0;
                        dbz_q <= 1'b0;
                    end
                end
                StUnpack: begin
                    sign_q    <= sign_ab;
                    special_q <= is_special;
                    exp_q     <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;
                    div_q     <= mb;
                    rem_q     <= {1'b0, ma};
                    quo_q     <= '0;
                    cnt_q     <= '0;
                    if (is_special) begin
                        res_q <= sp_res;
                        inv_q <= sp_inv;
                        dbz_q <= sp_dbz;
                    end
                end
                StDivide: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[QW-2:0], rem_ge};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                StNorm: begin
                    if (!special_q) begin
                        res_q <= norm_res;
                        of_q  <= norm_of;
                        uf_q  <= norm_uf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
